// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel frame loader for the 8-point FFT core.
// Collects eight complex samples over a valid/ready stream, presents them as a
// held frame on fft_in1..fft_in8, and delays each issue by the core latency to
// flag when the core outputs carry the matching transform.
module fft8_frame_loader #(
  parameter int DATA_W      = 32,
  parameter int FFT_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              sync,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [DATA_W-1:0] fft_in1,
  output logic [DATA_W-1:0] fft_in2,
  output logic [DATA_W-1:0] fft_in3,
  output logic [DATA_W-1:0] fft_in4,
  output logic [DATA_W-1:0] fft_in5,
  output logic [DATA_W-1:0] fft_in6,
  output logic [DATA_W-1:0] fft_in7,
  output logic [DATA_W-1:0] fft_in8,
  output logic              fft_out_valid,
  output logic [15:0]       frame_count
);

  localparam int NUM_LANES = 8;

  logic [NUM_LANES-2:0][DATA_W-1:0] coll;
  logic [NUM_LANES-1:0][DATA_W-1:0] issue_buf;
  logic [2:0]                       idx;
  logic [2:0]                       wr_idx;
  logic                             wr_en;
  logic                             accept;
  logic                             issue;
  logic                             load;
  logic [FFT_LATENCY:0]             vld_pipe;

  // The 8th sample can only land when the issue buffer is free or is being
  // drained on this same edge, so nothing is ever overwritten.
  assign s_ready = rst_n && ((idx != 3'd7) || !frame_valid || frame_ready);
  assign accept  = s_valid && s_ready;
  assign issue   = frame_valid && frame_ready;
  // sync realigns to slot 0, so a sync-coincident sample never completes a frame.
  assign load    = accept && !sync && (idx == 3'd7);
  assign wr_idx  = sync ? 3'd0 : idx;
  assign wr_en   = accept && (sync || (idx != 3'd7));

  // Write index: sync restarts the frame, accepting into slot 0 if a sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      idx <= 3'd0;
    else if (sync)   idx <= accept ? 3'd1 : 3'd0;
    else if (accept) idx <= idx + 3'd1;
  end

  // Collection slots 0..6; slot 7 is never stored, it goes straight to the issue buffer.
  for (genvar k = 0; k < NUM_LANES - 1; k++) begin : g_coll
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         coll[k] <= '0;
      else if (wr_en && (wr_idx == 3'(k))) coll[k] <= s_data;
    end
  end

  // Issue buffer: whole frame swapped in at once, held until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    issue_buf <= '0;
    else if (load) issue_buf <= {s_data, coll};
  end

  // Pending flag and issued-frame counter; a load on the issue edge keeps the flag high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      if (load)       frame_valid <= 1'b1;
      else if (issue) frame_valid <= 1'b0;
      if (issue)      frame_count <= frame_count + 16'd1;
    end
  end

  // Issue-delay line: stage 0 captures the issue edge, stage FFT_LATENCY lines
  // up with the core's registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[FFT_LATENCY-1:0], issue};
  end

  assign fft_out_valid = vld_pipe[FFT_LATENCY];

  assign fft_in1 = issue_buf[0];
  assign fft_in2 = issue_buf[1];
  assign fft_in3 = issue_buf[2];
  assign fft_in4 = issue_buf[3];
  assign fft_in5 = issue_buf[4];
  assign fft_in6 = issue_buf[5];
  assign fft_in7 = issue_buf[6];
  assign fft_in8 = issue_buf[7];

endmodule

// File: tb/tb_fft8_frame_loader.sv
// Bench for fft8_frame_loader: directed scenarios plus a randomized stream,
// all checked against a transaction-level model (sample queue, pending frame,
// list of edges at which a result strobe is due).
module tb_fft8_frame_loader;

  localparam int DW = 32;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          sync = 1'b0;
  logic          frame_ready = 1'b0;
  logic          s_ready, frame_valid, fft_out_valid;
  logic [DW-1:0] fft_in1, fft_in2, fft_in3, fft_in4, fft_in5, fft_in6, fft_in7, fft_in8;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  fft8_frame_loader #(.DATA_W(DW), .FFT_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sync(sync), .frame_ready(frame_ready), .frame_valid(frame_valid),
    .fft_in1(fft_in1), .fft_in2(fft_in2), .fft_in3(fft_in3), .fft_in4(fft_in4),
    .fft_in5(fft_in5), .fft_in6(fft_in6), .fft_in7(fft_in7), .fft_in8(fft_in8),
    .fft_out_valid(fft_out_valid), .frame_count(frame_count)
  );

  logic [7:0][DW-1:0] dut_frame;
  assign dut_frame = {fft_in8, fft_in7, fft_in6, fft_in5, fft_in4, fft_in3, fft_in2, fft_in1};

  // Reference model state
  logic [DW-1:0]      part[$];
  int                 due[$];
  logic               m_pend = 1'b0;
  logic [15:0]        m_cnt = '0;
  logic [7:0][DW-1:0] m_frame = '0;
  logic               exp_rdy = 1'b0, exp_pulse = 1'b0, rdy_seen = 1'b0;
  int                 edge_n = 0;
  int                 n_tests = 0, n_fail = 0;

  logic [274:0] obs_vec, exp_vec;
  assign obs_vec = {rdy_seen, frame_valid, fft_out_valid, frame_count, dut_frame};

  task automatic m_reset();
    part.delete();
    due.delete();
    m_pend = 1'b0;
    m_cnt = '0;
    m_frame = '0;
    exp_pulse = 1'b0;
  endtask

  // One clock: drive inputs on the falling edge, sample s_ready, then advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic sy, input logic fr);
    logic acc, iss, ld;
    @(negedge clk);
    s_valid = v; s_data = d; sync = sy; frame_ready = fr;
    exp_rdy = (part.size() != 7) || !m_pend || fr;
    #1 rdy_seen = s_ready;
    @(posedge clk);
    edge_n++;
    acc = v && exp_rdy;
    iss = m_pend && fr;
    ld  = 1'b0;
    if (iss) begin
      m_cnt = m_cnt + 16'd1;
      due.push_back(edge_n + L);
    end
    if (sy) begin
      part.delete();
      if (acc) part.push_back(d);
    end else if (acc) begin
      part.push_back(d);
      if (part.size() == 8) begin
        for (int k = 0; k < 8; k++) m_frame[k] = part[k];
        part.delete();
        ld = 1'b1;
      end
    end
    if (ld) m_pend = 1'b1;
    else if (iss) m_pend = 1'b0;
    exp_pulse = 1'b0;
    if (due.size() > 0 && due[0] == edge_n) begin
      exp_pulse = 1'b1;
      void'(due.pop_front());
    end
    exp_vec = {exp_rdy, m_pend, exp_pulse, m_cnt, m_frame};
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({s_ready, frame_valid, fft_out_valid, frame_count, dut_frame} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b fv=%b ov=%b cnt=%h frame=%h want all zero",
               s_ready, frame_valid, fft_out_valid, frame_count, dut_frame);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    #1;
    n_tests++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b want 1", s_ready);
    end
  endtask

  task automatic test_streaming();
    logic [7:0][DW-1:0] exp2;
    int pulses = 0;
    for (int k = 0; k < 22; k++) begin
      if (k < 16) step(1'b1, 32'(32'h0001_0000 * k), 1'b0, 1'b1);
      else        step(1'b0, '0, 1'b0, 1'b1);
      if (fft_out_valid) pulses++;
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL stream k=%0d got %h want %h", k, obs_vec, exp_vec);
      end
      if (k == 15) begin
        for (int j = 0; j < 8; j++) exp2[j] = 32'(32'h0001_0000 * (j + 8));
        n_tests++;
        if (dut_frame !== exp2 || frame_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_frame2 got fv=%b %h want fv=1 %h", frame_valid, dut_frame, exp2);
        end
      end
    end
    n_tests++;
    if (frame_count !== 16'd2 || pulses != 2) begin
      n_fail++;
      $display("FAIL stream_count got cnt=%0d pulses=%0d want cnt=2 pulses=2", frame_count, pulses);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 18; k++) begin
      if (k < 16)      step(1'b1, 32'hB000_0000 + 32'(k), 1'b0, 1'b0);
      else if (k == 16) step(1'b1, 32'hB000_000F, 1'b0, 1'b1);
      else              step(1'b0, '0, 1'b0, 1'b1);
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL backpressure k=%0d got %h want %h", k, obs_vec, exp_vec);
      end
      if (k == 15) begin
        n_tests++;
        if (rdy_seen !== 1'b0 || fft_in1 !== 32'hB000_0000 || fft_in8 !== 32'hB000_0007) begin
          n_fail++;
          $display("FAIL backpressure_stall got rdy=%b in1=%h in8=%h want 0 b0000000 b0000007",
                   rdy_seen, fft_in1, fft_in8);
        end
      end
      if (k == 16) begin
        n_tests++;
        if (frame_valid !== 1'b1 || fft_in1 !== 32'hB000_0008 || fft_in8 !== 32'hB000_000F) begin
          n_fail++;
          $display("FAIL backpressure_swap got fv=%b in1=%h in8=%h want 1 b0000008 b000000f",
                   frame_valid, fft_in1, fft_in8);
        end
      end
    end
    repeat (5) begin
      step(1'b0, '0, 1'b0, 1'b1);
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL backpressure_drain got %h want %h", obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_sync();
    logic [7:0][DW-1:0] exp_a;
    for (int j = 0; j < 8; j++) exp_a[j] = 32'h0000_00A0 + 32'(j);
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 5; k++) step(1'b1, 32'h0000_00C0 + 32'(k), 1'b0, 1'b1);
      if (pass == 0) step(1'b0, '0, 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) begin
        step(1'b1, 32'h0000_00A0 + 32'(k), (pass == 1 && k == 0), 1'b1);
        n_tests++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL sync pass=%0d k=%0d got %h want %h", pass, k, obs_vec, exp_vec);
        end
      end
      n_tests++;
      if (dut_frame !== exp_a || frame_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL sync_frame pass=%0d got fv=%b %h want fv=1 %h", pass, frame_valid, dut_frame, exp_a);
      end
      repeat (6) step(1'b0, '0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_impulse();
    int lat = 0;
    for (int k = 0; k < 8; k++) step(1'b1, (k == 0) ? 32'h3C00_0000 : 32'h0, 1'b0, 1'b0);
    n_tests++;
    if (dut_frame !== {224'h0, 32'h3C00_0000}) begin
      n_fail++;
      $display("FAIL impulse_frame got %h want in1=3c000000 rest 0", dut_frame);
    end
    step(1'b0, '0, 1'b0, 1'b1);
    while (!fft_out_valid && lat < 20) begin
      step(1'b0, '0, 1'b0, 1'b0);
      lat++;
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL impulse_cycle lat=%0d got %h want %h", lat, obs_vec, exp_vec);
      end
    end
    n_tests++;
    if (lat != L) begin
      n_fail++;
      $display("FAIL impulse_latency got %0d edges after issue want %0d", lat, L);
    end
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0][DW-1:0] exp_f;
    for (int k = 0; k < 8; k++) step(1'b1, 32'hD000_0000 + 32'(k), 1'b0, 1'b0);
    step(1'b1, 32'hD100_0001, 1'b0, 1'b1);
    step(1'b1, 32'hD100_0002, 1'b0, 1'b0);
    step(1'b1, 32'hD100_0003, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_tests++;
    if ({s_ready, frame_valid, fft_out_valid, frame_count, dut_frame} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async got rdy=%b fv=%b ov=%b cnt=%h frame=%h want all zero",
               s_ready, frame_valid, fft_out_valid, frame_count, dut_frame);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      edge_n++;
      #1;
      n_tests++;
      if (fft_out_valid !== 1'b0 || frame_count !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_mid_hold k=%0d got ov=%b cnt=%h want 0 0", k, fft_out_valid, frame_count);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k < 8) step(1'b1, 32'hE000_0000 + 32'(k), 1'b0, 1'b1);
      else       step(1'b0, '0, 1'b0, 1'b1);
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_mid_after k=%0d got %h want %h", k, obs_vec, exp_vec);
      end
    end
    for (int j = 0; j < 8; j++) exp_f[j] = 32'hE000_0000 + 32'(j);
    n_tests++;
    if (dut_frame !== exp_f || frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_mid_clean got cnt=%0d %h want cnt=1 %h", frame_count, dut_frame, exp_f);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    #1 release dut.frame_count;
    m_cnt = 16'hFFFF;
    #1;
    n_tests++;
    if (frame_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_preload got %h want ffff", frame_count);
    end
    for (int k = 0; k < 8; k++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    n_tests++;
    if (frame_count !== 16'h0000 || obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL wrap got cnt=%h vec=%h want cnt=0000 vec=%h", frame_count, obs_vec, exp_vec);
    end
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic v, sy, fr;
    for (int k = 0; k < 1500; k++) begin
      v  = ($urandom_range(0, 9) < 7);
      sy = ($urandom_range(0, 39) == 0);
      fr = $urandom_range(0, 1) == 1;
      step(v, $urandom, sy, fr);
      n_tests++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random k=%0d got %h want %h", k, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_sync();
    test_impulse();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case anything stalls.
  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
